vga_escalonador_embarcacoes: RTL and testbench

Sits between game logic and the five per-ship VGA renderers (submarino, cruzador, hidroaviao, encouracado, porta_avioes). Each renderer takes a 64-bit position vector. Game logic writes new positions and visibility through a req/ack handshake into shadow registers. The block commits pending shadows to the active vectors only on the frame-boundary pulse, so a ship never tears mid-frame. It also keeps a frame counter that renderers use for blinking.

---
 rtl/vga_escalonador_embarcacoes_pkg.sv | 12 +
 rtl/vga_registro_sombra.sv | 42 ++++
 rtl/vga_escalonador_embarcacoes.sv | 72 +++++++
 tb/tb_vga_escalonador_embarcacoes.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vga_escalonador_embarcacoes_pkg.sv
// vga_escalonador_embarcacoes_pkg: shared ship indices, widths and FSM encoding for the frame-synchronous position scheduler.
package vga_escalonador_embarcacoes_pkg;
  localparam int NUM_NAVIOS = 5;
  localparam int LARGURA_POS = 64;
  localparam int LARGURA_QUADRO = 6;
  localparam int SUBMARINO = 0;
  localparam int CRUZADOR = 1;
  localparam int HIDROAVIAO = 2;
  localparam int ENCOURACADO = 3;
  localparam int PORTA_AVIOES = 4;
  typedef enum logic [1:0] {OCIOSO = 2'd0, ESCRITA = 2'd1, COMMIT = 2'd2} estado_t;
endpackage

// File: rtl/vga_registro_sombra.sv
// vga_registro_sombra: one ship's shadow/active register pair; shadow loads on carregar, active takes it on commit if dirty.
module vga_registro_sombra
  import vga_escalonador_embarcacoes_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   carregar,
  input  logic                   commit,
  input  logic [LARGURA_POS-1:0] dado,
  input  logic                   vis,
  output logic [LARGURA_POS-1:0] ativo,
  output logic                   ativo_vis,
  output logic                   sujo
);
  logic [LARGURA_POS-1:0] sombra_q, sombra_d, ativo_q, ativo_d;
  logic sombra_vis_q, sombra_vis_d, ativo_vis_q, ativo_vis_d, sujo_q, sujo_d;
  always_comb begin
    sombra_d = carregar ? dado : sombra_q;
    sombra_vis_d = carregar ? vis : sombra_vis_q;
    ativo_d = (commit && sujo_q) ? sombra_q : ativo_q;
    ativo_vis_d = (commit && sujo_q) ? sombra_vis_q : ativo_vis_q;
    sujo_d = carregar ? 1'b1 : commit ? 1'b0 : sujo_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sombra_q <= '0;
      sombra_vis_q <= 1'b0;
      ativo_q <= '0;
      ativo_vis_q <= 1'b0;
      sujo_q <= 1'b0;
    end else begin
      sombra_q <= sombra_d;
      sombra_vis_q <= sombra_vis_d;
      ativo_q <= ativo_d;
      ativo_vis_q <= ativo_vis_d;
      sujo_q <= sujo_d;
    end
  end
  assign ativo = ativo_q;
  assign ativo_vis = ativo_vis_q;
  assign sujo = sujo_q;
endmodule

// File: rtl/vga_escalonador_embarcacoes.sv
// vga_escalonador_embarcacoes: buffers ship position writes and commits them only on frame boundaries to avoid tearing.
module vga_escalonador_embarcacoes
  import vga_escalonador_embarcacoes_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              fim_quadro,
  input  logic                              wr_req,
  input  logic [2:0]                        wr_sel,
  input  logic [LARGURA_POS-1:0]            wr_dado,
  input  logic                              wr_visivel,
  output logic                              wr_ack,
  output logic                              wr_erro,
  output logic [NUM_NAVIOS*LARGURA_POS-1:0] pos_ativas,
  output logic [NUM_NAVIOS-1:0]             visivel,
  output logic                              pendente,
  output logic [LARGURA_QUADRO-1:0]         quadro_cnt
);
  estado_t estado_q, estado_d;
  logic ack_q, ack_d, erro_q, erro_d, pegajoso_q, pegajoso_d;
  logic [LARGURA_QUADRO-1:0] quadro_q, quadro_d;
  logic [NUM_NAVIOS-1:0] carregar, sujo;
  logic commit;
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= OCIOSO;
      ack_q <= 1'b0;
      erro_q <= 1'b0;
      pegajoso_q <= 1'b0;
      quadro_q <= '0;
    end else begin
      estado_q <= estado_d;
      ack_q <= ack_d;
      erro_q <= erro_d;
      pegajoso_q <= pegajoso_d;
      quadro_q <= quadro_d;
    end
  end
  // The request is still high during the ack cycle, so it is ignored there to keep one write per handshake.
  always_comb begin
    estado_d = OCIOSO;
    if (estado_q == OCIOSO)
      estado_d = (fim_quadro || pegajoso_q) ? COMMIT : (wr_req && !ack_q) ? ESCRITA : OCIOSO;
    else if (estado_q == COMMIT)
      estado_d = wr_req ? ESCRITA : OCIOSO;
  end
  always_comb begin
    commit = estado_q == COMMIT;
    ack_d = estado_q == ESCRITA;
    erro_d = ack_d && int'(wr_sel) >= NUM_NAVIOS;
    pegajoso_d = commit ? 1'b0 : (ack_d && fim_quadro) ? 1'b1 : pegajoso_q;
    quadro_d = commit ? quadro_q + LARGURA_QUADRO'(1) : quadro_q;
    for (int i = 0; i < NUM_NAVIOS; i++) carregar[i] = ack_d && wr_sel == 3'(i);
  end
  for (genvar g = 0; g < NUM_NAVIOS; g++) begin : g_navio
    vga_registro_sombra u_sombra (
      .clk(clk),
      .reset(reset),
      .carregar(carregar[g]),
      .commit(commit),
      .dado(wr_dado),
      .vis(wr_visivel),
      .ativo(pos_ativas[g*LARGURA_POS +: LARGURA_POS]),
      .ativo_vis(visivel[g]),
      .sujo(sujo[g])
    );
  end
  assign wr_ack = ack_q;
  assign wr_erro = erro_q;
  assign pendente = |sujo;
  assign quadro_cnt = quadro_q;
endmodule

// File: tb/tb_vga_escalonador_embarcacoes.sv
// tb_vga_escalonador_embarcacoes: directed bench for the frame-synchronous ship position scheduler.
module tb_vga_escalonador_embarcacoes;
  import vga_escalonador_embarcacoes_pkg::*;
  logic clk, reset, fim_quadro, wr_req, wr_visivel, wr_ack, wr_erro, pendente;
  logic [2:0] wr_sel;
  logic [63:0] wr_dado;
  logic [319:0] pos_ativas;
  logic [4:0] visivel;
  logic [5:0] quadro_cnt;
  int checks = 0;
  int errors = 0;

  vga_escalonador_embarcacoes dut (
    .clk(clk), .reset(reset), .fim_quadro(fim_quadro), .wr_req(wr_req),
    .wr_sel(wr_sel), .wr_dado(wr_dado), .wr_visivel(wr_visivel),
    .wr_ack(wr_ack), .wr_erro(wr_erro), .pos_ativas(pos_ativas),
    .visivel(visivel), .pendente(pendente), .quadro_cnt(quadro_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame();
    fim_quadro = 1'b1;
    step();
    fim_quadro = 1'b0;
    step();
  endtask

  task automatic write_ship(input logic [2:0] sel, input logic [63:0] d, input logic v, input logic erro_exp);
    wr_req = 1'b1;
    wr_sel = sel;
    wr_dado = d;
    wr_visivel = v;
    step();
    step();
    chk("wr_ack", wr_ack, 1'b1);
    chk("wr_erro", wr_erro, erro_exp);
    wr_req = 1'b0;
    step();
    chk("wr_ack_single", wr_ack, 1'b0);
  endtask

  initial begin
    reset = 1'b1; fim_quadro = 1'b0; wr_req = 1'b0; wr_sel = '0; wr_dado = '0; wr_visivel = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_pos", pos_ativas, '0);
    chk("rst_vis", visivel, '0);
    chk("rst_ack", wr_ack, 1'b0);
    chk("rst_erro", wr_erro, 1'b0);
    chk("rst_pend", pendente, 1'b0);
    chk("rst_cnt", quadro_cnt, 6'd0);
    for (int k = 1; k <= 3; k++) begin
      frame();
      chk("idle_cnt", quadro_cnt, 6'(k));
    end
    chk("idle_pos", pos_ativas, '0);
    // ship 3 write, committed only after a frame boundary
    write_ship(3'(ENCOURACADO), 64'h12345, 1'b1, 1'b0);
    chk("w3_pend", pendente, 1'b1);
    chk("w3_pos_hold", pos_ativas[3*64 +: 64], 64'h0);
    chk("w3_vis_hold", visivel, 5'b00000);
    fim_quadro = 1'b1;
    step();
    fim_quadro = 1'b0;
    chk("w3_pos_commit_cycle", pos_ativas[3*64 +: 64], 64'h0);
    step();
    chk("w3_pos", pos_ativas[3*64 +: 64], 64'h12345);
    chk("w3_vis", visivel, 5'b01000);
    chk("w3_pend_clr", pendente, 1'b0);
    chk("w3_cnt", quadro_cnt, 6'd4);
    // last write wins
    write_ship(3'd0, 64'hAA, 1'b1, 1'b0);
    write_ship(3'd0, 64'hBB, 1'b1, 1'b0);
    frame();
    chk("lww_pos", pos_ativas, {64'h0, 64'h12345, 64'h0, 64'h0, 64'hBB});
    chk("lww_vis", visivel, 5'b01001);
    chk("lww_cnt", quadro_cnt, 6'd5);
    // out-of-range select
    write_ship(3'd6, 64'hDEAD, 1'b1, 1'b1);
    chk("bad_pend", pendente, 1'b0);
    frame();
    chk("bad_pos", pos_ativas, {64'h0, 64'h12345, 64'h0, 64'h0, 64'hBB});
    chk("bad_vis", visivel, 5'b01001);
    chk("bad_cnt", quadro_cnt, 6'd6);
    // frame boundary during ESCRITA is held and committed next
    wr_req = 1'b1; wr_sel = 3'd1; wr_dado = 64'hC0FFEE; wr_visivel = 1'b1;
    step();
    fim_quadro = 1'b1;
    step();
    fim_quadro = 1'b0;
    chk("sticky_ack", wr_ack, 1'b1);
    chk("sticky_pend", pendente, 1'b1);
    wr_req = 1'b0;
    step();
    chk("sticky_pos_hold", pos_ativas[1*64 +: 64], 64'h0);
    step();
    chk("sticky_pos", pos_ativas[1*64 +: 64], 64'hC0FFEE);
    chk("sticky_vis", visivel, 5'b01011);
    chk("sticky_pend_clr", pendente, 1'b0);
    chk("sticky_cnt", quadro_cnt, 6'd7);
    // fim_quadro beats wr_req in OCIOSO
    wr_req = 1'b1; wr_sel = 3'd2; wr_dado = 64'h77; wr_visivel = 1'b0; fim_quadro = 1'b1;
    step();
    fim_quadro = 1'b0;
    chk("prio_ack1", wr_ack, 1'b0);
    step();
    chk("prio_ack2", wr_ack, 1'b0);
    chk("prio_cnt", quadro_cnt, 6'd8);
    step();
    chk("prio_ack3", wr_ack, 1'b1);
    wr_req = 1'b0;
    step();
    chk("prio_ack4", wr_ack, 1'b0);
    chk("prio_pend", pendente, 1'b1);
    frame();
    chk("prio_pos", pos_ativas[2*64 +: 64], 64'h77);
    chk("prio_vis", visivel, 5'b01011);
    chk("prio_cnt2", quadro_cnt, 6'd9);
    // reset in ESCRITA
    wr_req = 1'b1; wr_sel = 3'd4; wr_dado = 64'h99; wr_visivel = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rst_mid_ack", wr_ack, 1'b0);
    wr_req = 1'b0;
    reset = 1'b0;
    step();
    chk("rst_mid_ack2", wr_ack, 1'b0);
    chk("rst_mid_pos", pos_ativas, '0);
    chk("rst_mid_vis", visivel, '0);
    chk("rst_mid_pend", pendente, 1'b0);
    chk("rst_mid_cnt", quadro_cnt, 6'd0);
    // counter wrap
    for (int k = 0; k < 63; k++) frame();
    chk("wrap_63", quadro_cnt, 6'd63);
    frame();
    chk("wrap_0", quadro_cnt, 6'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
